fft_frame_ctrl: RTL and testbench
=================================

# fft_frame_ctrl

Frame-level controller for the 256-point FFT engine and its shared 256x64 dual-port sample RAM. It captures one frame of ADC samples into the RAM over a valid/ready stream and pulses the FFT start. While the FFT runs it hands the RAM ports to the engine, then latches the peak-bin results. Once the frame is complete it gives a host read access to the spectrum. It sits between the sample source, `fft_top`, `DPRAM_WRAP`, and the host register interface.

## Interface
- `ADDR_WIDTH`, 8: RAM address width; frame length = 2^ADDR_WIDTH.
- `SAMPLE_WIDTH`, 12: input sample width.
- `RAM_DATA_WIDTH`, 64: RAM word width.
- `TIMEOUT_CYCLES`, 65535: maximum RUN duration before abort; 16-bit counter.

Ports (clock and reset first):
- `clk` in 1: single clock for all logic.
- `rst` in 1: reset, asynchronous and active-high.
- `arm` in 1: one-cycle pulse that begins capture of a new frame.
- `abort` in 1: return to IDLE from any state.
- `s_valid` in 1: sample valid.
- `s_ready` out 1: sample accepted when `s_valid` and `s_ready` are both high.
- `s_data` in SAMPLE_WIDTH: sample value.
- `fft_start` out 1: one-cycle start pulse to the FFT.
- `fft_done` in 1: FFT completion pulse.
- `fft_wen`, `fft_ren` in 1: FFT RAM write and read enables.
- `fft_waddr`, `fft_raddr` in ADDR_WIDTH: FFT RAM write and read addresses.
- `fft_wdata` in RAM_DATA_WIDTH: FFT RAM write data.
- `fft_max1`, `fft_max2` in ADDR_WIDTH: FFT peak bins, valid at `fft_done`.
- `ram_wen`, `ram_ren` out 1: enables to the DPRAM.
- `ram_waddr`, `ram_raddr` out ADDR_WIDTH: addresses to the DPRAM.
- `ram_wdata` out RAM_DATA_WIDTH: write data to the DPRAM.
- `ram_rdata` in RAM_DATA_WIDTH: DPRAM read data (1-cycle read latency).
- `host_ren` in 1: host read request.
- `host_raddr` in ADDR_WIDTH: host read address.
- `host_rdata` out RAM_DATA_WIDTH: host read data, equal to `ram_rdata`.
- `host_rvalid` out 1: `host_rdata` is valid.
- `busy` out 1: high in LOAD, START and RUN.
- `frame_ready` out 1: high in READY.
- `peak1_bin`, `peak2_bin` out ADDR_WIDTH: latched peak bins.
- `timeout_err` out 1: sticky timeout flag.

## Operation
- States: IDLE, LOAD, START, RUN, READY. Reset state is IDLE.
- IDLE:
  - `s_ready`=0; all RAM enables are 0.
  - `arm` -> LOAD; `wr_cnt` is cleared to 0.
- LOAD:
  - `s_ready`=1; `ram_wen`=`s_valid`; `ram_waddr`=`wr_cnt`; `ram_wdata`=zero-extended `s_data`.
  - Each accepted sample increments `wr_cnt`.
  - After the acceptance at `wr_cnt`=2^ADDR_WIDTH-1, go to START. `wr_cnt` wraps to 0 and no extra write occurs.
  - `arm` is ignored in LOAD.
- START:
  - `fft_start`=1 for exactly this cycle; go to RUN.
  - The timeout counter is cleared.
- RUN:
  - RAM ports are a combinational pass-through of the `fft_*` signals. `s_ready`=0.
  - The timeout counter increments every cycle.
  - `fft_done` -> latch `fft_max1`/`fft_max2` into `peak1_bin`/`peak2_bin`, go to READY.
  - Counter reaching TIMEOUT_CYCLES without `fft_done` -> set `timeout_err`, go to IDLE; the peak registers are unchanged.
  - If `fft_done` and the timeout occur in the same cycle, `fft_done` wins.
- READY:
  - `ram_ren`=`host_ren`; `ram_raddr`=`host_raddr`. The write port is idle.
  - `host_rvalid` = registered (`host_ren` and state==READY).
  - `arm` -> LOAD. This clears `frame_ready` and also clears `timeout_err`.
- `host_ren` outside READY is ignored: no RAM read, `host_rvalid` stays 0.
- `fft_done` outside RUN is ignored.
- `abort` (highest priority, any state) -> IDLE next cycle:
  - An `abort` asserted in the same cycle as `arm` wins.
  - Peak registers and `timeout_err` are held.
  - An abort during RUN leaves the FFT running; its writes are blocked from that cycle onward.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); a partially loaded frame is discarded.

## Timing
- Reset values: state IDLE; `wr_cnt`=0; timeout counter=0. All outputs are 0, including `fft_start`, `s_ready`, `busy`, `frame_ready`, `host_rvalid`, the peak registers and `timeout_err`.
- LOAD to START: 2^ADDR_WIDTH accepted samples, i.e. 256 cycles minimum at full rate. Backpressure is via `s_valid` gaps only; `s_ready` never drops inside LOAD.
- Last sample accept to `fft_start`: 1 cycle.
- `fft_start` to the first cycle of FFT RAM ownership: the next cycle.
- `fft_done` to `frame_ready`=1 and peaks valid: 1 cycle.
- Host read: `host_ren` in cycle N -> `host_rvalid`=1 with data in cycle N+1. Back-to-back reads are supported at 1 per cycle.
- Timeout fires on the cycle the counter equals TIMEOUT_CYCLES; `timeout_err` goes high the next cycle.

## Test plan
- Reset, then `arm`, then 256 samples 0x000..0xFF at full rate -> RAM[k]=k zero-extended, `fft_start` high exactly one cycle, 1 cycle after the 256th accept.
- Random `s_valid` gaps during LOAD -> exactly 256 writes, with no duplicate or skipped address.
- RUN with `fft_done`, `fft_max1`=0x12, `fft_max2`=0x34 -> `peak1_bin`=0x12, `peak2_bin`=0x34, `frame_ready`=1 the next cycle. Host reads of addresses 0x00 and 0xFF return the FFT-written words 1 cycle later.
- With TIMEOUT_CYCLES=100 and no `fft_done` -> `timeout_err`=1, state IDLE, peaks unchanged. Next `arm` clears `timeout_err`.
- `abort` together with `arm` in READY -> IDLE. `abort` at sample 100 of LOAD -> IDLE with `s_ready`=0, and a new `arm` restarts at address 0.
- `fft_done` in the same cycle as the timeout -> READY and no error. `host_ren` in IDLE -> `ram_ren`=0 and `host_rvalid`=0.

Source files
------------

// File: rtl/fft_frame_ctrl.sv
// Frame controller for the 256-point FFT engine and its shared sample RAM.
// Ports: arm/abort control; s_* sample stream; fft_* engine side; ram_* DPRAM
// side; host_* spectrum read port; busy/frame_ready/peak*_bin/timeout_err status.
module fft_frame_ctrl #(
    parameter int ADDR_WIDTH     = 8,
    parameter int SAMPLE_WIDTH   = 12,
    parameter int RAM_DATA_WIDTH = 64,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      arm,
    input  logic                      abort,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SAMPLE_WIDTH-1:0]   s_data,
    output logic                      fft_start,
    input  logic                      fft_done,
    input  logic                      fft_wen,
    input  logic                      fft_ren,
    input  logic [ADDR_WIDTH-1:0]     fft_waddr,
    input  logic [ADDR_WIDTH-1:0]     fft_raddr,
    input  logic [RAM_DATA_WIDTH-1:0] fft_wdata,
    input  logic [ADDR_WIDTH-1:0]     fft_max1,
    input  logic [ADDR_WIDTH-1:0]     fft_max2,
    output logic                      ram_wen,
    output logic                      ram_ren,
    output logic [ADDR_WIDTH-1:0]     ram_waddr,
    output logic [ADDR_WIDTH-1:0]     ram_raddr,
    output logic [RAM_DATA_WIDTH-1:0] ram_wdata,
    input  logic [RAM_DATA_WIDTH-1:0] ram_rdata,
    input  logic                      host_ren,
    input  logic [ADDR_WIDTH-1:0]     host_raddr,
    output logic [RAM_DATA_WIDTH-1:0] host_rdata,
    output logic                      host_rvalid,
    output logic                      busy,
    output logic                      frame_ready,
    output logic [ADDR_WIDTH-1:0]     peak1_bin,
    output logic [ADDR_WIDTH-1:0]     peak2_bin,
    output logic                      timeout_err
);

    typedef enum logic [2:0] {
        IDLE, LOAD, START, RUN, READY
    } state_t;

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   wr_cnt;
    logic [15:0]             tmo_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            wr_cnt      <= '0;
            tmo_cnt     <= '0;
            s_ready     <= 1'b0;
            fft_start   <= 1'b0;
            busy        <= 1'b0;
            frame_ready <= 1'b0;
            host_rvalid <= 1'b0;
            peak1_bin   <= '0;
            peak2_bin   <= '0;
            timeout_err <= 1'b0;
        end else begin
            fft_start   <= 1'b0;
            host_rvalid <= host_ren && (state == READY);
            if (abort) begin
                state       <= IDLE;
                s_ready     <= 1'b0;
                busy        <= 1'b0;
                frame_ready <= 1'b0;
            end else begin
                unique case (state)
                    IDLE, READY: begin
                        if (arm) begin
                            state       <= LOAD;
                            wr_cnt      <= '0;
                            timeout_err <= 1'b0;
                            s_ready     <= 1'b1;
                            busy        <= 1'b1;
                            frame_ready <= 1'b0;
                        end
                    end
                    LOAD: begin
                        if (s_valid) begin
                            // wraps to 0 on the last sample
                            wr_cnt <= wr_cnt + 1'b1;
                            if (wr_cnt == '1) begin
                                state     <= START;
                                s_ready   <= 1'b0;
                                fft_start <= 1'b1;
                            end
                        end
                    end
                    START: begin
                        state   <= RUN;
                        tmo_cnt <= '0;
                    end
                    RUN: begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        // completion beats a coincident timeout
                        if (fft_done) begin
                            state       <= READY;
                            peak1_bin   <= fft_max1;
                            peak2_bin   <= fft_max2;
                            busy        <= 1'b0;
                            frame_ready <= 1'b1;
                        end else if (tmo_cnt == TMO) begin
                            state       <= IDLE;
                            timeout_err <= 1'b1;
                            busy        <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // RAM port ownership follows the state; abort blocks writes immediately.
    always_comb begin
        ram_wen   = 1'b0;
        ram_ren   = 1'b0;
        ram_waddr = '0;
        ram_raddr = '0;
        ram_wdata = '0;
        unique case (state)
            LOAD: begin
                ram_wen   = s_valid & ~abort;
                ram_waddr = wr_cnt;
                ram_wdata = {{(RAM_DATA_WIDTH-SAMPLE_WIDTH){1'b0}}, s_data};
            end
            RUN: begin
                ram_wen   = fft_wen & ~abort;
                ram_ren   = fft_ren;
                ram_waddr = fft_waddr;
                ram_raddr = fft_raddr;
                ram_wdata = fft_wdata;
            end
            READY: begin
                ram_ren   = host_ren;
                ram_raddr = host_raddr;
            end
            default: ;
        endcase
    end

    assign host_rdata = ram_rdata;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl with a behavioural DPRAM model.
// Drives at posedge+1, samples at negedge.
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        arm, abort, s_valid, s_ready;
    logic [11:0] s_data;
    logic        fft_start, fft_done, fft_wen, fft_ren;
    logic [7:0]  fft_waddr, fft_raddr, fft_max1, fft_max2;
    logic [63:0] fft_wdata;
    logic        ram_wen, ram_ren;
    logic [7:0]  ram_waddr, ram_raddr;
    logic [63:0] ram_wdata, ram_rdata, host_rdata;
    logic        host_ren, host_rvalid;
    logic [7:0]  host_raddr;
    logic        busy, frame_ready, timeout_err;
    logic [7:0]  peak1_bin, peak2_bin;

    localparam logic [63:0] W0 = 64'hDEAD_BEEF_0000_0001;
    localparam logic [63:0] WF = 64'hCAFE_F00D_0000_00FF;

    int nvec = 0;
    int nerr = 0;

    logic [63:0] mem [256];
    int          wcnt [256];
    int          nwr = 0;
    int          nstart = 0;
    int          base [256];
    int          nwr_base;
    int          nstart_base;

    always #5 clk = ~clk;

    fft_frame_ctrl #(.TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .rst(rst), .arm(arm), .abort(abort),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .fft_start(fft_start), .fft_done(fft_done),
        .fft_wen(fft_wen), .fft_ren(fft_ren),
        .fft_waddr(fft_waddr), .fft_raddr(fft_raddr),
        .fft_wdata(fft_wdata),
        .fft_max1(fft_max1), .fft_max2(fft_max2),
        .ram_wen(ram_wen), .ram_ren(ram_ren),
        .ram_waddr(ram_waddr), .ram_raddr(ram_raddr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .host_ren(host_ren), .host_raddr(host_raddr),
        .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .busy(busy), .frame_ready(frame_ready),
        .peak1_bin(peak1_bin), .peak2_bin(peak2_bin),
        .timeout_err(timeout_err)
    );

    initial for (int i = 0; i < 256; i++) wcnt[i] = 0;

    always @(posedge clk) begin
        if (ram_wen) begin
            mem[ram_waddr]  <= ram_wdata;
            wcnt[ram_waddr] <= wcnt[ram_waddr] + 1;
            nwr             <= nwr + 1;
        end
        if (ram_ren) ram_rdata <= mem[ram_raddr];
        if (fft_start) nstart <= nstart + 1;
    end

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic snap();
        for (int i = 0; i < 256; i++) base[i] = wcnt[i];
        nwr_base    = nwr;
        nstart_base = nstart;
    endtask

    task automatic load(input bit gaps, input logic [11:0] xv);
        int acc = 0;
        int cyc = 0;
        bit drop = 0;
        while (acc < 256 && cyc < 3000) begin
            s_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            s_data  = 12'(acc) ^ xv;
            @(negedge clk);
            if (!s_ready) drop = 1;
            if (s_valid && s_ready) acc++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        chk("load_accepts", 64'(acc), 64'd256);
        chk("s_ready_held", 64'(drop), 64'd0);
    endtask

    task automatic chk_writes();
        int bad = 0;
        for (int i = 0; i < 256; i++)
            if (wcnt[i] - base[i] != 1) bad++;
        chk("write_total", 64'(nwr - nwr_base), 64'd256);
        chk("write_unique", 64'(bad), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        arm = 0; abort = 0; s_valid = 0; s_data = 0;
        fft_done = 0; fft_wen = 0; fft_ren = 0;
        fft_waddr = 0; fft_raddr = 0; fft_wdata = 0;
        fft_max1 = 0; fft_max2 = 0;
        host_ren = 0; host_raddr = 0;
        repeat (3) @(negedge clk);
        chk("rst_s_ready", 64'(s_ready), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_frame_ready", 64'(frame_ready), 0);
        chk("rst_fft_start", 64'(fft_start), 0);
        chk("rst_peaks", {peak1_bin, peak2_bin}, 0);
        chk("rst_tmo", 64'(timeout_err), 0);
        chk("rst_rvalid", 64'(host_rvalid), 0);
        tick();
        rst = 1'b0;
        tick();

        // host read in IDLE is ignored
        host_ren = 1'b1; host_raddr = 8'h05;
        @(negedge clk);
        chk("idle_ram_ren", 64'(ram_ren), 0);
        tick();
        host_ren = 1'b0;
        @(negedge clk);
        chk("idle_rvalid", 64'(host_rvalid), 0);
        tick();

        // full-rate frame 0x000..0x0FF
        snap();
        pulse_arm();
        load(1'b0, 12'h000);
        @(negedge clk);
        chk("fft_start_hi", 64'(fft_start), 1);
        chk_writes();
        chk("mem_00", mem[0], 64'h0);
        chk("mem_7f", mem[8'h7F], 64'h7F);
        chk("mem_ff", mem[8'hFF], 64'hFF);
        tick();
        fft_wen = 1; fft_waddr = 8'h00; fft_wdata = W0;
        fft_ren = 1; fft_raddr = 8'h10;
        @(negedge clk);
        chk("fft_start_lo", 64'(fft_start), 0);
        chk("run_busy", 64'(busy), 1);
        chk("run_wen", 64'(ram_wen), 1);
        chk("run_ren", 64'(ram_ren), 1);
        chk("run_raddr", 64'(ram_raddr), 64'h10);
        tick();
        fft_ren = 0;
        fft_waddr = 8'hFF; fft_wdata = WF;
        @(negedge clk);
        chk("run_waddr", 64'(ram_waddr), 64'hFF);
        chk("run_wdata", ram_wdata, WF);
        tick();
        fft_wen = 0;
        fft_done = 1; fft_max1 = 8'h12; fft_max2 = 8'h34;
        tick();
        fft_done = 0;
        @(negedge clk);
        chk("rdy_frame_ready", 64'(frame_ready), 1);
        chk("rdy_busy", 64'(busy), 0);
        chk("rdy_peak1", 64'(peak1_bin), 64'h12);
        chk("rdy_peak2", 64'(peak2_bin), 64'h34);
        chk("start_count", 64'(nstart - nstart_base), 1);

        // back-to-back host reads
        tick();
        host_ren = 1; host_raddr = 8'h00;
        @(negedge clk);
        chk("host_ram_ren", 64'(ram_ren), 1);
        chk("host_ram_raddr", 64'(ram_raddr), 0);
        chk("host_no_wen", 64'(ram_wen), 0);
        tick();
        host_raddr = 8'hFF;
        @(negedge clk);
        chk("host_rvalid0", 64'(host_rvalid), 1);
        chk("host_rdata0", host_rdata, W0);
        tick();
        host_ren = 0;
        @(negedge clk);
        chk("host_rvalid1", 64'(host_rvalid), 1);
        chk("host_rdataff", host_rdata, WF);
        tick();
        @(negedge clk);
        chk("host_rvalid_off", 64'(host_rvalid), 0);
        tick();

        // gapped frame then timeout
        snap();
        pulse_arm();
        @(negedge clk);
        chk("rearm_frame_ready", 64'(frame_ready), 0);
        chk("rearm_s_ready", 64'(s_ready), 1);
        tick();
        load(1'b1, 12'hA50);
        @(negedge clk);
        chk("gap_fft_start", 64'(fft_start), 1);
        chk_writes();
        chk("gap_mem_03", mem[3], 64'hA53);
        chk("gap_mem_ff", mem[8'hFF], 64'hAAF);
        n = 0;
        for (int c = 0; c < 500; c++) begin
            tick();
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        chk("tmo_run_len", 64'(n), 64'd101);
        chk("tmo_err", 64'(timeout_err), 1);
        chk("tmo_idle_s_ready", 64'(s_ready), 0);
        chk("tmo_frame_ready", 64'(frame_ready), 0);
        chk("tmo_peaks", 64'({peak1_bin, peak2_bin}), 64'h1234);
        tick();

        // arm clears error, abort at sample 100
        pulse_arm();
        @(negedge clk);
        chk("arm_clr_tmo", 64'(timeout_err), 0);
        tick();
        for (int k = 0; k < 100; k++) begin
            s_valid = 1; s_data = 12'(k);
            tick();
        end
        abort = 1;
        @(negedge clk);
        chk("abort_blk_wen", 64'(ram_wen), 0);
        tick();
        abort = 0; s_valid = 0;
        @(negedge clk);
        chk("abort_s_ready", 64'(s_ready), 0);
        chk("abort_busy", 64'(busy), 0);
        tick();
        snap();
        pulse_arm();
        @(negedge clk);
        chk("restart_addr", 64'(ram_waddr), 0);
        tick();
        load(1'b0, 12'h000);
        @(negedge clk);
        chk("re_fft_start", 64'(fft_start), 1);
        chk_writes();

        // fft_done coincident with timeout
        repeat (101) tick();
        fft_done = 1; fft_max1 = 8'h56; fft_max2 = 8'h78;
        tick();
        fft_done = 0;
        @(negedge clk);
        chk("race_ready", 64'(frame_ready), 1);
        chk("race_no_err", 64'(timeout_err), 0);
        chk("race_peaks", 64'({peak1_bin, peak2_bin}), 64'h5678);
        tick();

        // abort beats arm in READY
        arm = 1; abort = 1;
        tick();
        arm = 0; abort = 0;
        @(negedge clk);
        chk("abarm_busy", 64'(busy), 0);
        chk("abarm_s_ready", 64'(s_ready), 0);
        chk("abarm_frame_ready", 64'(frame_ready), 0);
        chk("abarm_peaks", 64'({peak1_bin, peak2_bin}), 64'h5678);
        tick();

        // fft_done and host_ren in IDLE are ignored
        fft_done = 1; fft_max1 = 8'h99; fft_max2 = 8'h99;
        host_ren = 1;
        @(negedge clk);
        chk("idle2_ram_ren", 64'(ram_ren), 0);
        tick();
        fft_done = 0; host_ren = 0;
        @(negedge clk);
        chk("idle2_rvalid", 64'(host_rvalid), 0);
        chk("idle2_peaks", 64'({peak1_bin, peak2_bin}), 64'h5678);
        chk("idle2_ready", 64'(frame_ready), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
